if_fetch_unit: RTL
==================

// Module: if_fetch_unit
// PURPOSE
//   Instruction-fetch stage directly downstream of program_counter. Issues one imem read per PC,
//   queues {pc, instr} in an in-order fetch queue, and presents them to the IF/ID register via
//   valid/ready. Drives pc_stall back into program_counter when no request can be issued.
//   Flush (branch/trap redirect) discards queued and in-flight fetches.
// PARAMETERS
//   PC_WIDTH     64  address width, matches program_counter
//   INSTR_WIDTH  32  instruction word width
//   FQ_DEPTH     4   fetch-queue entries; power of 2, >=2; bounds outstanding imem requests
// PORTS
//   clk             in   1            clock, rising edge
//   reset_n         in   1            asynchronous active-low reset
//   pc_in           in   PC_WIDTH     current PC (program_counter.PC_out)
//   pc_stall        out  1            1 = hold PC; feeds program_counter.stall
//   flush           in   1            redirect; kill all queued and in-flight fetches
//   imem_req_valid  out  1            imem read request valid
//   imem_req_ready  in   1            imem accepts request
//   imem_req_addr   out  PC_WIDTH     request address (= pc_in)
//   imem_rsp_valid  in   1            read data valid; responses in request order
//   imem_rsp_data   in   INSTR_WIDTH  read data
//   if_valid        out  1            head entry valid toward IF/ID
//   if_ready        in   1            IF/ID accepts head
//   if_pc           out  PC_WIDTH     PC of head entry
//   if_instr        out  INSTR_WIDTH  instruction of head entry
//   perf_stall_cnt  out  32           only with FETCH_PERF_CNT_EN
// BEHAVIOUR
//   - Reset (reset_n=0, async): queue empty, pointers/drop_cnt 0, if_valid=0, if_pc=0, if_instr=0,
//     imem_req_valid=0, pc_stall=1. Reset mid-transfer drops everything; no response is retained.
//   - Queue entry = {pc, instr, filled}. Entry allocated at request handshake (pc written),
//     filled at response (instr written, filled=1), freed at if_valid&&if_ready.
//   - Pointers log2(FQ_DEPTH)+1 bits; full = MSBs differ and low bits equal; empty = equal.
//   - imem_req_valid = reset_n && !full && !flush; imem_req_addr = pc_in (combinational).
//   - pc_stall = !(imem_req_valid && imem_req_ready), except pc_stall=0 during flush so the PC
//     loads the redirect target. PC advances exactly once per accepted request.
//   - if_valid = !empty && head.filled && !flush. if_pc/if_instr from head entry (registered).
//   - Latency: request accepted cycle N; rsp earliest N+1; if_valid earliest cycle after rsp.
//     No response-to-output bypass.
//   - Response with drop_cnt>0: discarded, drop_cnt-1. Otherwise fills the oldest unfilled entry.
//   - Flush: next state empty queue; drop_cnt <= (allocated-unfilled count) minus 1 if a
//     non-dropped rsp arrives same cycle; plus drop_cnt if already nonzero. No request issued.
//   - Flush beats simultaneous dequeue, allocate and fill. Dequeue+allocate in same cycle when
//     full: allocate refused (full evaluated on current state).
//   - imem response with no outstanding request: ignored (assertion in bench).
// CONFIGURATION
//   FETCH_PERF_CNT_EN defined: port perf_stall_cnt present; 32-bit counter increments each cycle
//     pc_stall=1 && reset_n && !flush; reset to 0; wraps 0xFFFF_FFFF -> 0.
//   Not defined: port and counter absent; all other behaviour identical.
// STRUCTURE
//   Shared package fetch_pkg: FQ entry layout/widths, PTR_W = $clog2(FQ_DEPTH)+1, RESET_PC.
//   Sub-module fetch_queue: storage, alloc/fill/dequeue pointers, full/empty, flush clear.
//   Top holds handshake logic, drop_cnt, pc_stall, optional perf counter.
// TESTING
//   1 Reset: reset_n=0 mid-stream -> all outputs at reset values same cycle; pc_stall=1.
//   2 Streaming: req_ready=1, rsp 1 cycle later, pc 0,4,8,... instr 0x13 -> if_pc 0,4,8 in order,
//     one per cycle after 2-cycle fill, pc_stall=0 throughout.
//   3 Full: if_ready=0, FQ_DEPTH=4 -> 4 requests accepted, then imem_req_valid=0, pc_stall=1;
//     if_ready=1 -> issue resumes the cycle after first dequeue.
//   4 Flush with 2 in flight: assert flush, redirect pc 0x100 -> 2 rsps dropped, next if_pc=0x100.
//   5 Flush + rsp + if_ready same cycle -> queue empty next cycle, drop_cnt accounts rsp correctly.
//   6 imem_req_ready=0 for 5 cycles -> PC held, perf_stall_cnt=5 (FETCH_PERF_CNT_EN).

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: default widths,
// fetch-queue pointer sizing and the reset PC held in empty queue slots.
package fetch_pkg;

  localparam int DEF_PC_WIDTH    = 64;
  localparam int DEF_INSTR_WIDTH = 32;
  localparam int DEF_FQ_DEPTH    = 4;

  // Pointer width for the default depth: one wrap bit above the index.
  localparam int PTR_W = $clog2(DEF_FQ_DEPTH) + 1;

  // Headroom bits above the pointer width for the drop counter. Each flush
  // adds at most FQ_DEPTH orphaned requests.
  localparam int DROP_HEADROOM = 4;

  localparam logic [63:0] RESET_PC = 64'h0;

  // Pointer width for an arbitrary queue depth.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch queue. Entries are allocated when the imem request is
// accepted, filled in order as responses return, and freed from the head.
// Three pointers: alloc (tail), fill (oldest unfilled), head (oldest).
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int PC_WIDTH    = DEF_PC_WIDTH,
  parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
  parameter int FQ_DEPTH    = DEF_FQ_DEPTH,
  localparam int QPTR_W     = ptr_w(FQ_DEPTH)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_flush,
  input  logic                   i_alloc,
  input  logic [PC_WIDTH-1:0]    i_alloc_pc,
  input  logic                   i_fill,
  input  logic [INSTR_WIDTH-1:0] i_fill_instr,
  input  logic                   i_deq,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [QPTR_W-1:0]      o_outstanding,
  output logic                   o_head_filled,
  output logic [PC_WIDTH-1:0]    o_head_pc,
  output logic [INSTR_WIDTH-1:0] o_head_instr
);

  localparam int IDX_W = QPTR_W - 1;

  typedef struct packed {
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] instr;
    logic                   filled;
  } entry_t;

  entry_t            r_mem [FQ_DEPTH];
  logic [QPTR_W-1:0] r_head;
  logic [QPTR_W-1:0] r_fill;
  logic [QPTR_W-1:0] r_alloc;

  logic [IDX_W-1:0]  w_head_idx;
  logic [IDX_W-1:0]  w_fill_idx;
  logic [IDX_W-1:0]  w_alloc_idx;

  assign w_head_idx  = r_head[IDX_W-1:0];
  assign w_fill_idx  = r_fill[IDX_W-1:0];
  assign w_alloc_idx = r_alloc[IDX_W-1:0];

  assign o_full        = (r_alloc[QPTR_W-1] != r_head[QPTR_W-1]) &&
                         (r_alloc[IDX_W-1:0] == r_head[IDX_W-1:0]);
  assign o_empty       = (r_alloc == r_head);
  assign o_outstanding = r_alloc - r_fill;
  assign o_head_filled = r_mem[w_head_idx].filled;
  assign o_head_pc     = r_mem[w_head_idx].pc;
  assign o_head_instr  = r_mem[w_head_idx].instr;

  // Storage and pointers. Alloc only targets a free slot and fill only an
  // allocated one, so the per-slot writes below never collide.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head  <= '0;
      r_fill  <= '0;
      r_alloc <= '0;
      for (int i = 0; i < FQ_DEPTH; i++) begin
        r_mem[i] <= '{pc: RESET_PC[PC_WIDTH-1:0], instr: '0, filled: 1'b0};
      end
    end else if (i_flush) begin
      r_head  <= '0;
      r_fill  <= '0;
      r_alloc <= '0;
      for (int i = 0; i < FQ_DEPTH; i++) begin
        r_mem[i].filled <= 1'b0;
      end
    end else begin
      if (i_alloc) begin
        r_mem[w_alloc_idx].pc     <= i_alloc_pc;
        r_mem[w_alloc_idx].filled <= 1'b0;
        r_alloc                   <= r_alloc + 1'b1;
      end
      if (i_fill) begin
        r_mem[w_fill_idx].instr  <= i_fill_instr;
        r_mem[w_fill_idx].filled <= 1'b1;
        r_fill                   <= r_fill + 1'b1;
      end
      if (i_deq) begin
        r_head <= r_head + 1'b1;
      end
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: issues one imem read per PC, queues {pc, instr}
// in order and hands them to IF/ID via valid/ready. Flush discards queued
// entries and counts in-flight requests whose responses must be dropped.
// Optional build macro FETCH_PERF_CNT_EN adds perf_stall_cnt.
module if_fetch_unit
  import fetch_pkg::*;
#(
  parameter int PC_WIDTH    = DEF_PC_WIDTH,
  parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
  parameter int FQ_DEPTH    = DEF_FQ_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [PC_WIDTH-1:0]    pc_in,
  output logic                   pc_stall,
  input  logic                   flush,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [PC_WIDTH-1:0]    imem_req_addr,
  input  logic                   imem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
  output logic                   if_valid,
  input  logic                   if_ready,
  output logic [PC_WIDTH-1:0]    if_pc,
  output logic [INSTR_WIDTH-1:0] if_instr
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]            perf_stall_cnt
`endif
);

  localparam int QPTR_W = ptr_w(FQ_DEPTH);
  localparam int DROP_W = QPTR_W + DROP_HEADROOM;

  logic              w_full;
  logic              w_empty;
  logic [QPTR_W-1:0] w_outstanding;
  logic              w_has_out;
  logic              w_head_filled;
  logic              w_alloc;
  logic              w_fill;
  logic              w_deq;
  logic              w_drop_nz;
  logic              w_rsp_drop;
  logic              w_rsp_cnt;
  logic [DROP_W-1:0] r_drop_cnt;

  // Request side: address passes straight through from the PC.
  assign imem_req_valid = reset_n && !w_full && !flush;
  assign imem_req_addr  = pc_in;
  assign w_alloc        = imem_req_valid && imem_req_ready;

  // Hold the PC unless a request was taken; release it on flush so the
  // redirect target loads.
  assign pc_stall = !reset_n || (!flush && !w_alloc);

  // Response side: dropped responses are drained before any fill.
  assign w_has_out  = (w_outstanding != '0);
  assign w_drop_nz  = (r_drop_cnt != '0);
  assign w_rsp_drop = imem_rsp_valid && w_drop_nz;
  assign w_fill     = imem_rsp_valid && !w_drop_nz && w_has_out && !flush;
  // A response that consumes either a pending drop or an outstanding slot.
  assign w_rsp_cnt  = imem_rsp_valid && (w_drop_nz || w_has_out);

  // Output side.
  assign if_valid = !w_empty && w_head_filled && !flush;
  assign w_deq    = if_valid && if_ready;

  fetch_queue #(
    .PC_WIDTH    (PC_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH),
    .FQ_DEPTH    (FQ_DEPTH)
  ) u_fq (
    .i_clk         (clk),
    .i_rst_n       (reset_n),
    .i_flush       (flush),
    .i_alloc       (w_alloc),
    .i_alloc_pc    (pc_in),
    .i_fill        (w_fill),
    .i_fill_instr  (imem_rsp_data),
    .i_deq         (w_deq),
    .o_full        (w_full),
    .o_empty       (w_empty),
    .o_outstanding (w_outstanding),
    .o_head_filled (w_head_filled),
    .o_head_pc     (if_pc),
    .o_head_instr  (if_instr)
  );

  // Drop counter: on flush, every allocated-but-unfilled request becomes an
  // orphan, less the one whose response lands this same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_drop_cnt <= '0;
    end else if (flush) begin
      r_drop_cnt <= r_drop_cnt + DROP_W'(w_outstanding) - DROP_W'(w_rsp_cnt);
    end else if (w_rsp_drop) begin
      r_drop_cnt <= r_drop_cnt - 1'b1;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_cnt;

  // Stall-cycle counter; wraps naturally at 32 bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_cnt <= '0;
    end else if (pc_stall && !flush) begin
      r_perf_cnt <= r_perf_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt = r_perf_cnt;
`endif

endmodule
